// File: rtl/pipeline_ctrl_pkg.sv
// Shared state encodings, drain-counter width and output polarity constants
// for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      PCTL_RUN    = 2'd0,
      PCTL_MDWAIT = 2'd1,
      PCTL_DRAIN  = 2'd2,
      PCTL_TRAPJ  = 2'd3
   } pctl_state_t;

   localparam int PCTL_CNT_W = 3;
   localparam int REG_ADDR_W = 5;

   localparam logic PLFLUSH_ENABLE = 1'b1;
   localparam logic PC_STOP_ENABLE = 1'b1;

   typedef struct packed {
      logic stall_pc;
      logic hold_fd;
      logic flush_fd;
      logic hold_de;
      logic flush_de;
      logic redirect;
      logic trap_ack;
   } pctl_ctrl_t;

   // Maps an internal active-high request onto the consumer's assertion level.
   function automatic logic drive_level(input logic active, input logic enable_level);
      return active ? enable_level : ~enable_level;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a dependency).
module pipeline_ctrl_hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic                  load_ex,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   output logic                  hazard
);

   logic rs1_hit;
   logic rs2_hit;
   logic rd_live;

   assign rs1_hit = rs1_used & (rs1_id == rd_ex);
   assign rs2_hit = rs2_used & (rs2_id == rd_ex);
   assign rd_live = (rd_ex != '0);
   assign hazard  = load_ex & rd_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core (load-use, branch,
// mul/div wait, trap drain). Optional perf counters: define PIPE_CTRL_PERF_EN.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        load_ex_i,
   input  logic [4:0]  rd_ex_i,
   input  logic [4:0]  rs1_id_i,
   input  logic [4:0]  rs2_id_i,
   input  logic        rs1_used_i,
   input  logic        rs2_used_i,
   input  logic        md_start_i,
   input  logic        md_done_i,
   input  logic        trap_req_i,
   input  logic [31:0] trap_vec_i,
   output logic        stall_pc_o,
   output logic        hold_fd_o,
   output logic        flush_fd_o,
   output logic        hold_de_o,
   output logic        flush_de_o,
   output logic        redirect_o,
   output logic [31:0] redirect_addr_o,
   output logic        trap_ack_o,
   output logic        busy_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   localparam logic [PCTL_CNT_W-1:0] DRAIN_LAST = PCTL_CNT_W'(DRAIN_CYCLES - 1);

   pctl_state_t           state_q;
   pctl_state_t           state_d;
   logic [PCTL_CNT_W-1:0] drain_cnt_q;
   logic [PCTL_CNT_W-1:0] drain_cnt_d;
   logic [31:0]           trap_vec_q;
   logic [31:0]           trap_vec_d;

   logic                  load_use;
   pctl_ctrl_t            ctrl;
   logic [31:0]           redir_addr;

   pipeline_ctrl_hazard_detect u_hazard_detect (
      .load_ex  (load_ex_i),
      .rd_ex    (rd_ex_i),
      .rs1_id   (rs1_id_i),
      .rs2_id   (rs2_id_i),
      .rs1_used (rs1_used_i),
      .rs2_used (rs2_used_i),
      .hazard   (load_use)
   );

   // State register, drain counter and the vector captured at trap acceptance.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= PCTL_RUN;
         drain_cnt_q <= '0;
         trap_vec_q  <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         trap_vec_q  <= trap_vec_d;
      end
   end

   always_comb begin : next_state
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      trap_vec_d  = trap_vec_q;
      case (state_q)
         PCTL_RUN: begin
            if (trap_req_i) begin
               state_d     = PCTL_DRAIN;
               drain_cnt_d = '0;
               trap_vec_d  = trap_vec_i;
            end else if (!branch_taken_i && md_start_i) begin
               state_d = PCTL_MDWAIT;
            end
         end
         PCTL_MDWAIT: begin
            if (md_done_i) begin
               state_d = PCTL_RUN;
            end
         end
         PCTL_DRAIN: begin
            drain_cnt_d = drain_cnt_q + PCTL_CNT_W'(1);
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = PCTL_TRAPJ;
            end
         end
         PCTL_TRAPJ: begin
            state_d = PCTL_RUN;
         end
         default: begin
            state_d = PCTL_RUN;
         end
      endcase
   end

   // Mealy outputs; a trap request in RUN deliberately produces no action.
   always_comb begin : output_decode
      ctrl       = '0;
      redir_addr = '0;
      case (state_q)
         PCTL_RUN: begin
            if (trap_req_i) begin
               ctrl = '0;
            end else if (branch_taken_i) begin
               ctrl.redirect = 1'b1;
               ctrl.flush_fd = 1'b1;
               ctrl.flush_de = 1'b1;
               redir_addr    = branch_target_i;
            end else if (md_start_i) begin
               ctrl.stall_pc = 1'b1;
               ctrl.hold_fd  = 1'b1;
               ctrl.hold_de  = 1'b1;
            end else if (load_use) begin
               ctrl.stall_pc = 1'b1;
               ctrl.hold_fd  = 1'b1;
               ctrl.flush_de = 1'b1;
            end
         end
         PCTL_MDWAIT: begin
            if (!md_done_i) begin
               ctrl.stall_pc = 1'b1;
               ctrl.hold_fd  = 1'b1;
               ctrl.hold_de  = 1'b1;
            end
         end
         PCTL_DRAIN: begin
            ctrl.stall_pc = 1'b1;
            ctrl.flush_fd = 1'b1;
            ctrl.flush_de = 1'b1;
         end
         PCTL_TRAPJ: begin
            ctrl.redirect = 1'b1;
            ctrl.flush_fd = 1'b1;
            ctrl.flush_de = 1'b1;
            ctrl.trap_ack = 1'b1;
            redir_addr    = trap_vec_q;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

   // Reset gates every output so nothing leaks through while rst_i is low;
   // a flush on a register always wins over a hold on the same register.
   logic       out_en;
   pctl_ctrl_t act;

   assign out_en = rst_i;

   always_comb begin : output_gate
      act          = '0;
      act.stall_pc = out_en & ctrl.stall_pc;
      act.flush_fd = out_en & ctrl.flush_fd;
      act.flush_de = out_en & ctrl.flush_de;
      act.hold_fd  = out_en & ctrl.hold_fd & ~ctrl.flush_fd;
      act.hold_de  = out_en & ctrl.hold_de & ~ctrl.flush_de;
      act.redirect = out_en & ctrl.redirect;
      act.trap_ack = out_en & ctrl.trap_ack;
   end

   assign stall_pc_o      = drive_level(act.stall_pc, PC_STOP_ENABLE);
   assign flush_fd_o      = drive_level(act.flush_fd, PLFLUSH_ENABLE);
   assign flush_de_o      = drive_level(act.flush_de, PLFLUSH_ENABLE);
   assign hold_fd_o       = act.hold_fd;
   assign hold_de_o       = act.hold_de;
   assign redirect_o      = act.redirect;
   assign redirect_addr_o = act.redirect ? redir_addr : 32'd0;
   assign trap_ack_o      = act.trap_ack;
   assign busy_o          = out_en & (state_q != PCTL_RUN);

`ifdef PIPE_CTRL_PERF_EN
   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (act.stall_pc) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
         if (act.flush_de) begin
            flush_cnt_o <= flush_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural reference model.
module tb_pipeline_ctrl;

   localparam int DRAIN = 2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic        load_ex_i;
   logic [4:0]  rd_ex_i;
   logic [4:0]  rs1_id_i;
   logic [4:0]  rs2_id_i;
   logic        rs1_used_i;
   logic        rs2_used_i;
   logic        md_start_i;
   logic        md_done_i;
   logic        trap_req_i;
   logic [31:0] trap_vec_i;
   logic        stall_pc_o;
   logic        hold_fd_o;
   logic        flush_fd_o;
   logic        hold_de_o;
   logic        flush_de_o;
   logic        redirect_o;
   logic [31:0] redirect_addr_o;
   logic        trap_ack_o;
   logic        busy_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   pipeline_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .load_ex_i       (load_ex_i),
      .rd_ex_i         (rd_ex_i),
      .rs1_id_i        (rs1_id_i),
      .rs2_id_i        (rs2_id_i),
      .rs1_used_i      (rs1_used_i),
      .rs2_used_i      (rs2_used_i),
      .md_start_i      (md_start_i),
      .md_done_i       (md_done_i),
      .trap_req_i      (trap_req_i),
      .trap_vec_i      (trap_vec_i),
      .stall_pc_o      (stall_pc_o),
      .hold_fd_o       (hold_fd_o),
      .flush_fd_o      (flush_fd_o),
      .hold_de_o       (hold_de_o),
      .flush_de_o      (flush_de_o),
      .redirect_o      (redirect_o),
      .redirect_addr_o (redirect_addr_o),
      .trap_ack_o      (trap_ack_o),
      .busy_o          (busy_o)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cnt_o     (stall_cnt_o),
      .flush_cnt_o     (flush_cnt_o)
`endif
   );

   typedef struct packed {
      logic        stall;
      logic        hold_fd;
      logic        flush_fd;
      logic        hold_de;
      logic        flush_de;
      logic        redirect;
      logic [31:0] addr;
      logic        ack;
      logic        busy;
   } out_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   out_t obs;
   out_t exp;

   // Reference model: pending mul/div, remaining drain cycles, pending jump.
   bit          m_md_pending   = 1'b0;
   int          m_drain_left   = 0;
   bit          m_jump_pending = 1'b0;
   logic [31:0] m_vec          = 32'd0;

   function automatic out_t mk(bit st, bit hf, bit ff, bit hd, bit fd, bit rd,
                               logic [31:0] a, bit ak, bit bz);
      out_t o;
      o.stall = st; o.hold_fd = hf; o.flush_fd = ff; o.hold_de = hd;
      o.flush_de = fd; o.redirect = rd; o.addr = a; o.ack = ak; o.busy = bz;
      return o;
   endfunction

   function automatic out_t dut_out();
      return {stall_pc_o, hold_fd_o, flush_fd_o, hold_de_o, flush_de_o,
              redirect_o, redirect_addr_o, trap_ack_o, busy_o};
   endfunction

   function automatic bit ref_hazard();
      return load_ex_i && rd_ex_i != 0 &&
             ((rs1_used_i && rs1_id_i == rd_ex_i) || (rs2_used_i && rs2_id_i == rd_ex_i));
   endfunction

   function automatic out_t model_out();
      if (!rst_i)              return mk(0,0,0,0,0,0,0,0,0);
      if (m_jump_pending)      return mk(0,0,1,0,1,1,m_vec,1,1);
      if (m_drain_left > 0)    return mk(1,0,1,0,1,0,0,0,1);
      if (m_md_pending)        return md_done_i ? mk(0,0,0,0,0,0,0,0,1) : mk(1,1,0,1,0,0,0,0,1);
      if (trap_req_i)          return mk(0,0,0,0,0,0,0,0,0);
      if (branch_taken_i)      return mk(0,0,1,0,1,1,branch_target_i,0,0);
      if (md_start_i)          return mk(1,1,0,1,0,0,0,0,0);
      if (ref_hazard())        return mk(1,1,0,0,1,0,0,0,0);
      return mk(0,0,0,0,0,0,0,0,0);
   endfunction

   task automatic model_step();
      if (!rst_i) begin
         m_md_pending = 0; m_drain_left = 0; m_jump_pending = 0; m_vec = 0;
      end else if (m_jump_pending) begin
         m_jump_pending = 0;
      end else if (m_drain_left > 0) begin
         m_drain_left--;
         if (m_drain_left == 0) m_jump_pending = 1;
      end else if (m_md_pending) begin
         if (md_done_i) m_md_pending = 0;
      end else if (trap_req_i) begin
         m_drain_left = DRAIN;
         m_vec        = trap_vec_i;
      end else if (!branch_taken_i && md_start_i) begin
         m_md_pending = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
   endtask

   task automatic clear_inputs();
      branch_taken_i = 0; branch_target_i = 0; load_ex_i = 0; rd_ex_i = 0;
      rs1_id_i = 0; rs2_id_i = 0; rs1_used_i = 0; rs2_used_i = 0;
      md_start_i = 0; md_done_i = 0; trap_req_i = 0; trap_vec_i = 0;
   endtask

   task automatic test_reset();
      rst_i = 0;
      branch_taken_i = 1; branch_target_i = 32'hCAFE_0000; md_start_i = 1;
      load_ex_i = 1; rd_ex_i = 5'd7; rs1_id_i = 5'd7; rs1_used_i = 1;
      #1 obs = dut_out(); exp = mk(0,0,0,0,0,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL reset_hold: got %h want %h", obs, exp); else n_pass++;
      tick();
      rst_i = 1; clear_inputs();
      #1 obs = dut_out();
      n_checks++; if (obs !== exp) $display("FAIL reset_release: got %h want %h", obs, exp); else n_pass++;
      tick();
   endtask

   task automatic test_load_use();
      clear_inputs();
      load_ex_i = 1; rd_ex_i = 5'd5; rs2_id_i = 5'd5; rs2_used_i = 1; rs1_id_i = 5'd3; rs1_used_i = 1;
      #1 obs = dut_out(); exp = mk(1,1,0,0,1,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL load_use_rs2: got %h want %h", obs, exp); else n_pass++;
      tick();
      clear_inputs();
      #1 obs = dut_out(); exp = mk(0,0,0,0,0,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL load_use_after: got %h want %h", obs, exp); else n_pass++;
      tick();
      load_ex_i = 1; rd_ex_i = 5'd0; rs2_id_i = 5'd0; rs2_used_i = 1;
      #1 obs = dut_out();
      n_checks++; if (obs !== exp) $display("FAIL load_use_x0: got %h want %h", obs, exp); else n_pass++;
      tick();
      load_ex_i = 1; rd_ex_i = 5'd9; rs1_id_i = 5'd9; rs1_used_i = 0; rs2_used_i = 0;
      #1 obs = dut_out();
      n_checks++; if (obs !== exp) $display("FAIL load_use_unused: got %h want %h", obs, exp); else n_pass++;
      tick();
      rs1_used_i = 1;
      #1 obs = dut_out(); exp = mk(1,1,0,0,1,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL load_use_rs1: got %h want %h", obs, exp); else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_branch();
      clear_inputs();
      branch_taken_i = 1; branch_target_i = 32'h0000_0100; md_start_i = 1;
      #1 obs = dut_out(); exp = mk(0,0,1,0,1,1,32'h0000_0100,0,0);
      n_checks++; if (obs !== exp) $display("FAIL branch_taken: got %h want %h", obs, exp); else n_pass++;
      tick();
      clear_inputs();
      #1 obs = dut_out(); exp = mk(0,0,0,0,0,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL branch_md_ignored: got %h want %h", obs, exp); else n_pass++;
      tick();
   endtask

   task automatic test_mdwait();
      clear_inputs();
      md_start_i = 1; md_done_i = 1;
      #1 obs = dut_out(); exp = mk(1,1,0,1,0,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL md_start: got %h want %h", obs, exp); else n_pass++;
      tick();
      md_start_i = 0; md_done_i = 0;
      for (int c = 1; c < 5; c++) begin
         trap_req_i = (c >= 2); trap_vec_i = 32'h0000_1234;
         #1 obs = dut_out(); exp = mk(1,1,0,1,0,0,0,0,1);
         n_checks++; if (obs !== exp) $display("FAIL md_wait_c%0d: got %h want %h", c, obs, exp); else n_pass++;
         tick();
      end
      md_done_i = 1;
      #1 obs = dut_out(); exp = mk(0,0,0,0,0,0,0,0,1);
      n_checks++; if (obs !== exp) $display("FAIL md_done: got %h want %h", obs, exp); else n_pass++;
      tick();
      md_done_i = 0;
      #1 obs = dut_out(); exp = mk(0,0,0,0,0,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL md_trap_accept: got %h want %h", obs, exp); else n_pass++;
      tick();
      for (int c = 0; c < DRAIN; c++) begin
         #1 obs = dut_out(); exp = mk(1,0,1,0,1,0,0,0,1);
         n_checks++; if (obs !== exp) $display("FAIL md_trap_drain%0d: got %h want %h", c, obs, exp); else n_pass++;
         tick();
      end
      #1 obs = dut_out(); exp = mk(0,0,1,0,1,1,32'h0000_1234,1,1);
      n_checks++; if (obs !== exp) $display("FAIL md_trap_jump: got %h want %h", obs, exp); else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_trap();
      clear_inputs();
      trap_req_i = 1; trap_vec_i = 32'h8000_0040; branch_taken_i = 1; branch_target_i = 32'h44;
      #1 obs = dut_out(); exp = mk(0,0,0,0,0,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL trap_accept: got %h want %h", obs, exp); else n_pass++;
      tick();
      branch_taken_i = 0;
      for (int c = 0; c < DRAIN; c++) begin
         trap_vec_i = 32'hDEAD_BEEF;
         #1 obs = dut_out(); exp = mk(1,0,1,0,1,0,0,0,1);
         n_checks++; if (obs !== exp) $display("FAIL trap_drain%0d: got %h want %h", c, obs, exp); else n_pass++;
         tick();
      end
      #1 obs = dut_out(); exp = mk(0,0,1,0,1,1,32'h8000_0040,1,1);
      n_checks++; if (obs !== exp) $display("FAIL trap_jump: got %h want %h", obs, exp); else n_pass++;
      tick();
      trap_req_i = 0;
      #1 obs = dut_out(); exp = mk(0,0,0,0,0,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL trap_done: got %h want %h", obs, exp); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_drain();
      clear_inputs();
      trap_req_i = 1; trap_vec_i = 32'h8000_0040;
      tick();
      #1 obs = dut_out(); exp = mk(1,0,1,0,1,0,0,0,1);
      n_checks++; if (obs !== exp) $display("FAIL rst_drain1: got %h want %h", obs, exp); else n_pass++;
      tick();
      rst_i = 0;
      #1 obs = dut_out(); exp = mk(0,0,0,0,0,0,0,0,0);
      n_checks++; if (obs !== exp) $display("FAIL rst_in_drain: got %h want %h", obs, exp); else n_pass++;
      tick();
      rst_i = 1; trap_req_i = 0;
      for (int c = 0; c < 4; c++) begin
         #1 obs = dut_out();
         n_checks++; if (obs !== exp) $display("FAIL rst_after%0d: got %h want %h", c, obs, exp); else n_pass++;
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst_i           = ($urandom_range(0, 99) != 0);
         branch_taken_i  = ($urandom_range(0, 7) == 0);
         branch_target_i = $urandom;
         load_ex_i       = ($urandom_range(0, 1) == 1);
         rd_ex_i         = 5'($urandom_range(0, 3));
         rs1_id_i        = 5'($urandom_range(0, 3));
         rs2_id_i        = 5'($urandom_range(0, 3));
         rs1_used_i      = ($urandom_range(0, 1) == 1);
         rs2_used_i      = ($urandom_range(0, 1) == 1);
         md_start_i      = ($urandom_range(0, 9) == 0);
         md_done_i       = ($urandom_range(0, 3) == 0);
         trap_req_i      = ($urandom_range(0, 15) == 0);
         trap_vec_i      = $urandom;
         #1 obs = dut_out(); exp = model_out();
         n_checks++; if (obs !== exp) $display("FAIL random_c%0d: got %h want %h", i, obs, exp); else n_pass++;
         tick();
      end
      rst_i = 1; clear_inputs();
   endtask

`ifdef PIPE_CTRL_PERF_EN
   task automatic test_perf();
      clear_inputs();
      rst_i = 0; tick(); rst_i = 1;
      #1;
      n_checks++;
      if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0)
         $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         load_ex_i = 1; rd_ex_i = 5'd4; rs1_id_i = 5'd4; rs1_used_i = 1;
         tick();
         clear_inputs();
         tick();
      end
      md_start_i = 1; tick(); md_start_i = 0;
      repeat (4) tick();
      md_done_i = 1; tick(); md_done_i = 0;
      tick();
      #1;
      n_checks++;
      if (stall_cnt_o !== 32'd8 || flush_cnt_o !== 32'd3)
         $display("FAIL perf_counts: got %0d/%0d want 8/3", stall_cnt_o, flush_cnt_o);
      else n_pass++;
   endtask
`endif

   initial begin
      clear_inputs();
      rst_i = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      test_reset();
      test_load_use();
      test_branch();
      test_mdwait();
      test_trap();
      test_reset_mid_drain();
      test_random();
`ifdef PIPE_CTRL_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
